modport_fsm: RTL and testbench
==============================

# modport_fsm

Two-floor lift controller: a Moore state machine that drives the car motor (enable and direction) and the cabin fan from the call buttons, the door-closed switch and the floor limit sensors. It sits behind the lift interface. The stimulus side drives the buttons and sensors; the controller returns its state code, motor controls and fan enable, and both are sampled by a monitor.

## Interface
- FAN_HOLD, default 4: cycles the fan keeps running after the car stops at a floor (range 0..255).

- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- up_button  input  1  call to travel up (meaningful only at ground).
- down_button  input  1  call to travel down (meaningful only at top).
- doors_closed  input  1  1 = doors closed and locked.
- top_floor  input  1  top limit sensor, 1 = car at top.
- ground_floor  input  1  ground limit sensor, 1 = car at ground.
- state  output  3  current state code.
- motor_on  output  1  1 = motor energised.
- motor_direction  output  1  1 = up, 0 = down.
- fan_on  output  1  cabin fan enable.

## Operation
State codes:
- GROUND=0: motor_on=0, motor_direction=0.
- UP=1: motor_on=1, motor_direction=1.
- TOP=2: motor_on=0, motor_direction=0.
- DOWN=3: motor_on=1, motor_direction=0.
- HALT_UP=4: motor_on=0, motor_direction=1.
- HALT_DOWN=5: motor_on=0, motor_direction=0.

Transitions, evaluated at each rising clk; the first matching rule wins:
- GROUND -> UP when up_button & doors_closed & !top_floor. down_button is ignored in GROUND.
- UP -> TOP when top_floor.
- UP -> HALT_UP when !doors_closed.
- HALT_UP -> UP when doors_closed.
- TOP -> DOWN when down_button & doors_closed & !ground_floor. up_button is ignored in TOP.
- DOWN -> GROUND when ground_floor.
- DOWN -> HALT_DOWN when !doors_closed.
- HALT_DOWN -> DOWN when doors_closed.
- Codes 6 and 7 -> GROUND on the next edge.
- Otherwise the state holds.

Boundary conditions:
- Arrival has priority over door opening: in UP, top_floor=1 with doors open goes to TOP.
- The sensor not matching the travel direction is ignored (ground_floor in UP, top_floor in DOWN).
- up_button and down_button together in GROUND: up is served.

Fan:
- fan_on=1 in UP, DOWN, HALT_UP and HALT_DOWN.
- On each transition UP->TOP or DOWN->GROUND, a hold counter loads FAN_HOLD. fan_on stays 1 while the counter is non-zero; the counter decrements once per cycle in GROUND/TOP.
- Leaving GROUND/TOP into motion clears the counter.
- FAN_HOLD=0: fan_on drops on the arrival edge.

## Timing
- Reset (rst=0, asynchronous):
  - state=GROUND (0), motor_on=0, motor_direction=0, fan_on=0, hold counter=0.
  - Release is synchronised internally with a two-flop deassert synchroniser.
- Outputs are decoded from registered state and counter only, with no combinational path from the inputs.
- An input sampled at edge N is reflected on the outputs just after edge N. The bench samples 1 time unit after the following edge.
- Fan after arrival: fan_on stays 1 for exactly FAN_HOLD cycles after the arrival edge, then drops.
- Reset asserted mid-travel stops the motor immediately, independent of clk.

## Structure
- Shared package lift_pkg:
  - a state enum typedef (3-bit, the codes above);
  - the motor direction constants DIR_UP=1 and DIR_DOWN=0.
- One sub-module, lift_fan_timer: holds the FAN_HOLD down-counter, with load, clear and active outputs.
- The FSM, output decode and reset synchroniser live in modport_fsm.

## Test plan
- Reset: rst=0 -> state=0, motor_on=0, motor_direction=0, fan_on=0, checked before any clk edge.
- Normal up trip, from GROUND:
  - up_button=1, doors_closed=1 -> state=1, motor_on=1, motor_direction=1, fan_on=1.
  - Then top_floor=1 -> state=2, motor_on=0.
  - fan_on=1 for 4 cycles, then 0.
- Normal down trip, from TOP:
  - down_button=1, doors_closed=1 -> state=3, motor_on=1, motor_direction=0.
  - Then ground_floor=1 -> state=0.
- Door open in UP:
  - doors_closed=0 -> state=4, motor_on=0, motor_direction=1, fan_on=1.
  - doors_closed=1 -> state=1, motor_on=1.
- Blocked departures:
  - GROUND with up_button=1, doors_closed=0 -> state stays 0.
  - GROUND with down_button=1 only -> state stays 0.
  - TOP with up_button=1 -> state stays 2.
- Reset mid-travel and simultaneous buttons:
  - rst=0 while in state 3 -> all outputs 0 at once.
  - In GROUND, up_button=down_button=1 with doors closed -> state=1.

Source files
------------

// File: rtl/lift_pkg.sv
// Shared types for the two-floor lift controller: state codes, motor direction
// constants and the next-state rule table.
package lift_pkg;

   typedef enum logic [2:0] {
      GROUND    = 3'd0,
      UP        = 3'd1,
      TOP       = 3'd2,
      DOWN      = 3'd3,
      HALT_UP   = 3'd4,
      HALT_DOWN = 3'd5
   } lift_state_t;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Arrival is tested before the door switch so a car reaching its floor with
   // the doors open still parks instead of halting.
   function automatic lift_state_t lift_next(
      input lift_state_t cur,
      input logic        up_button,
      input logic        down_button,
      input logic        doors_closed,
      input logic        top_floor,
      input logic        ground_floor
   );
      lift_state_t nxt;
      nxt = cur;
      case (cur)
         GROUND:    if (up_button && doors_closed && !top_floor) nxt = UP;
         UP:        if (top_floor) nxt = TOP;
                    else if (!doors_closed) nxt = HALT_UP;
         HALT_UP:   if (doors_closed) nxt = UP;
         TOP:       if (down_button && doors_closed && !ground_floor) nxt = DOWN;
         DOWN:      if (ground_floor) nxt = GROUND;
                    else if (!doors_closed) nxt = HALT_DOWN;
         HALT_DOWN: if (doors_closed) nxt = DOWN;
         default:   nxt = GROUND;
      endcase
      return nxt;
   endfunction

   function automatic logic in_travel(input lift_state_t s);
      return (s == UP) || (s == DOWN) || (s == HALT_UP) || (s == HALT_DOWN);
   endfunction

endpackage

// File: rtl/modport_fsm_if.sv
// Lift interface: call buttons and sensors from the stimulus side, state code,
// motor controls and fan enable back from the controller.
interface lift_if;
   logic       up_button;
   logic       down_button;
   logic       doors_closed;
   logic       top_floor;
   logic       ground_floor;
   logic [2:0] state;
   logic       motor_on;
   logic       motor_direction;
   logic       fan_on;

   modport master (
      output up_button, down_button, doors_closed, top_floor, ground_floor,
      input  state, motor_on, motor_direction, fan_on
   );

   modport slave (
      input  up_button, down_button, doors_closed, top_floor, ground_floor,
      output state, motor_on, motor_direction, fan_on
   );
endinterface

// File: rtl/lift_fan_timer.sv
// Fan run-on counter: loads HOLD when the car arrives at a floor and counts
// down while parked; active while non-zero.
module lift_fan_timer #(
   parameter int unsigned HOLD = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic clear,
   input  logic count_en,
   output logic active
);
   localparam logic [7:0] HOLD_V = 8'(HOLD);

   logic [7:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= 8'd0;
      end else if (load) begin
         count_reg <= HOLD_V;
      end else if (clear) begin
         count_reg <= 8'd0;
      end else if (count_en && (count_reg != 8'd0)) begin
         count_reg <= count_reg - 8'd1;
      end
   end

   assign active = (count_reg != 8'd0);
endmodule

// File: rtl/modport_fsm.sv
// Two-floor lift controller: Moore FSM driving motor enable/direction and the
// cabin fan, with reset asserted asynchronously and released through two flops.
module modport_fsm
   import lift_pkg::*;
#(
   parameter int unsigned FAN_HOLD = 4
) (
   input  logic  clk,
   input  logic  rst,
   lift_if.slave bus
);
   logic [1:0]  sync_reg;
   logic        run;
   lift_state_t state_reg;
   lift_state_t state_next;
   logic        motor_on_reg;
   logic        motor_dir_reg;
   logic        parked;
   logic        arrive;
   logic        depart;
   logic        fan_active;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_reg <= 2'b00;
      else      sync_reg <= {sync_reg[0], 1'b1};
   end

   assign run = sync_reg[1];

   always_comb begin
      state_next = lift_next(state_reg, bus.up_button, bus.down_button,
                             bus.doors_closed, bus.top_floor, bus.ground_floor);
      parked     = (state_reg == GROUND) || (state_reg == TOP);
      arrive     = ((state_reg == UP)   && (state_next == TOP)) ||
                   ((state_reg == DOWN) && (state_next == GROUND));
      depart     = parked && (state_next != state_reg);
   end

   // Motor outputs are registered from the next state so they change on the
   // same edge as the state code.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= GROUND;
         motor_on_reg  <= 1'b0;
         motor_dir_reg <= DIR_DOWN;
      end else if (!run) begin
         state_reg     <= GROUND;
         motor_on_reg  <= 1'b0;
         motor_dir_reg <= DIR_DOWN;
      end else begin
         state_reg <= state_next;
         case (state_next)
            UP: begin
               motor_on_reg  <= 1'b1;
               motor_dir_reg <= DIR_UP;
            end
            DOWN: begin
               motor_on_reg  <= 1'b1;
               motor_dir_reg <= DIR_DOWN;
            end
            HALT_UP: begin
               motor_on_reg  <= 1'b0;
               motor_dir_reg <= DIR_UP;
            end
            default: begin
               motor_on_reg  <= 1'b0;
               motor_dir_reg <= DIR_DOWN;
            end
         endcase
      end
   end

   lift_fan_timer #(
      .HOLD (FAN_HOLD)
   ) u_fan_timer (
      .clk      (clk),
      .rst_n    (rst),
      .load     (run && arrive),
      .clear    (!run || depart),
      .count_en (parked),
      .active   (fan_active)
   );

   assign bus.state           = state_reg;
   assign bus.motor_on        = motor_on_reg;
   assign bus.motor_direction = motor_dir_reg;
   assign bus.fan_on          = in_travel(state_reg) || fan_active;
endmodule

// File: tb/tb_modport_fsm.sv
// Scoreboard bench for the lift controller: stimulus pushes expected outputs,
// a monitor pops and compares one sample after each rising edge.
module tb_modport_fsm;
   logic clk;
   logic rst;

   lift_if bus ();

   modport_fsm #(
      .FAN_HOLD (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [5:0] outs;
      string      name;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [5:0] sample_outs();
      return {bus.state, bus.motor_on, bus.motor_direction, bus.fan_on};
   endfunction

   task automatic compare(input string nm, input logic [5:0] act, input logic [5:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s state/motor/dir/fan got=%b required=%b", nm, act, req);
      end else begin
         $display("txn %-12s state=%0d motor_on=%b dir=%b fan=%b", nm,
                  act[5:3], act[2], act[1], act[0]);
      end
   endtask

   // inp = {up, down, doors_closed, top, ground}; exp = {state[2:0], motor_on, dir, fan}
   task automatic step(input logic [4:0] inp, input logic [5:0] exp, input string nm);
      exp_t e;
      bus.up_button    = inp[4];
      bus.down_button  = inp[3];
      bus.doors_closed = inp[2];
      bus.top_floor    = inp[1];
      bus.ground_floor = inp[0];
      e.outs = exp;
      e.name = nm;
      q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            compare(e.name, sample_outs(), e.outs);
         end
      end
   end

   initial begin : watchdog
      #50000;
      $display("FAIL timeout simulation did not finish got=running required=done");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      rst              = 1'b0;
      bus.up_button    = 1'b0;
      bus.down_button  = 1'b0;
      bus.doors_closed = 1'b0;
      bus.top_floor    = 1'b0;
      bus.ground_floor = 1'b0;
      #1;
      compare("reset", sample_outs(), 6'b000_0_0_0);

      @(posedge clk);
      #2;
      rst = 1'b1;
      step(5'b00000, 6'b000_0_0_0, "idle0");
      step(5'b00001, 6'b000_0_0_0, "idle1");
      step(5'b00001, 6'b000_0_0_0, "idle2");

      // Blocked departures from GROUND
      step(5'b10001, 6'b000_0_0_0, "blk_doors");
      step(5'b01101, 6'b000_0_0_0, "blk_down");

      // Up trip with a door-open halt
      step(5'b10101, 6'b001_1_1_1, "go_up");
      step(5'b00101, 6'b001_1_1_1, "up_ign_gnd");
      step(5'b00000, 6'b100_0_1_1, "halt_up");
      step(5'b00100, 6'b001_1_1_1, "resume_up");
      step(5'b00010, 6'b010_0_0_1, "arrive_top");
      step(5'b10110, 6'b010_0_0_1, "top_ub_f3");
      step(5'b10110, 6'b010_0_0_1, "fan2");
      step(5'b10110, 6'b010_0_0_1, "fan1");
      step(5'b10110, 6'b010_0_0_0, "fan_off");

      // Down trip with a door-open halt
      step(5'b01110, 6'b011_1_0_1, "go_down");
      step(5'b00110, 6'b011_1_0_1, "dn_ign_top");
      step(5'b00000, 6'b101_0_0_1, "halt_down");
      step(5'b00100, 6'b011_1_0_1, "resume_dn");
      step(5'b00101, 6'b000_0_0_1, "arrive_gnd");
      step(5'b00101, 6'b000_0_0_1, "gnd_f3");
      step(5'b00101, 6'b000_0_0_1, "gnd_f2");
      step(5'b00101, 6'b000_0_0_1, "gnd_f1");
      step(5'b00101, 6'b000_0_0_0, "gnd_f_off");

      // Both buttons at ground, then back down for a mid-travel reset
      step(5'b11101, 6'b001_1_1_1, "both_btn");
      step(5'b00110, 6'b010_0_0_1, "top_again");
      step(5'b01110, 6'b011_1_0_1, "down_again");

      rst = 1'b0;
      #1;
      compare("rst_mid", sample_outs(), 6'b000_0_0_0);
      @(posedge clk);
      #1;
      compare("rst_held", sample_outs(), 6'b000_0_0_0);
      #1;
      rst = 1'b1;
      step(5'b00000, 6'b000_0_0_0, "post_rst0");
      step(5'b00000, 6'b000_0_0_0, "post_rst1");
      step(5'b10101, 6'b001_1_1_1, "go_up2");

      @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain pending got=%0d required=0", q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
